// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default word geometry, the zero word
// and the accumulate-sequencer state encoding.
package fp_pkg;

   localparam int unsigned FP_DATA_WIDTH = 32;
   localparam int unsigned FP_M          = 23;
   localparam int unsigned FP_E          = 8;

   localparam logic [FP_DATA_WIDTH-1:0] FP_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCEPT = 2'd1,
      ADD    = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/floating_point_adder.sv
// Combinational IEEE-754 style adder (sign / E-bit exponent / M-bit fraction).
// A zero-exponent operand is treated as zero and the other operand passes
// through unchanged; exact cancellation yields +0. Round to nearest even on
// three guard bits; no NaN/Inf/denormal handling.
//   in1, in2 : operands
//   out      : in1 + in2
module floating_point_adder #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned M          = 23,
   parameter int unsigned E          = 8
) (
   input  logic [DATA_WIDTH-1:0] in1,
   input  logic [DATA_WIDTH-1:0] in2,
   output logic [DATA_WIDTH-1:0] out
);

   // hidden bit + fraction + three guard bits
   localparam int unsigned XW = M + 4;

   logic [DATA_WIDTH-1:0] big;
   logic [DATA_WIDTH-1:0] sml;
   logic [E-1:0]          exp_diff;
   logic [E-1:0]          lz;
   logic [E-1:0]          exp_r;
   logic [XW-1:0]         m_big;
   logic [XW-1:0]         m_sml;
   logic [XW:0]           raw;
   logic [XW:0]           norm;
   logic                  found;
   logic                  round_up;
   logic [DATA_WIDTH-1:0] packed_r;

   always_comb begin
      // Order by magnitude so the aligned difference is never negative.
      if (in1[DATA_WIDTH-2:0] >= in2[DATA_WIDTH-2:0]) begin
         big = in1;
         sml = in2;
      end else begin
         big = in2;
         sml = in1;
      end

      exp_diff = big[DATA_WIDTH-2 -: E] - sml[DATA_WIDTH-2 -: E];
      m_big    = {1'b1, big[M-1:0], 3'b000};
      m_sml    = {1'b1, sml[M-1:0], 3'b000} >> exp_diff;

      if (big[DATA_WIDTH-1] == sml[DATA_WIDTH-1]) begin
         raw = {1'b0, m_big} + {1'b0, m_sml};
      end else begin
         raw = {1'b0, m_big - m_sml};
      end

      // Leading-zero count over the raw result, including the carry bit.
      lz    = '0;
      found = 1'b0;
      for (int i = int'(XW); i >= 0; i--) begin
         if (!found) begin
            if (raw[i]) found = 1'b1;
            else        lz    = lz + E'(1);
         end
      end

      norm  = raw << lz;
      exp_r = big[DATA_WIDTH-2 -: E] + E'(1) - lz;

      // A fraction carry from rounding ripples into the exponent field.
      round_up = norm[3] & ((|norm[2:0]) | norm[4]);
      packed_r = {big[DATA_WIDTH-1], exp_r, norm[XW-1 -: M]} + DATA_WIDTH'(round_up);

      if (in1[DATA_WIDTH-2 -: E] == '0) begin
         out = in2;
      end else if (in2[DATA_WIDTH-2 -: E] == '0) begin
         out = in1;
      end else if (!norm[XW]) begin
         out = '0;
      end else begin
         out = packed_r;
      end
   end

endmodule

// File: rtl/fp_accum_sequencer.sv
// Reduces a stream of N floating-point values to their sum by time-
// multiplexing one floating_point_adder over an accumulator register.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, len           : begin a reduction of len elements (IDLE only)
//   in_valid/in_ready    : element input handshake, in_data payload
//   sum_valid/sum_ready  : result handshake, sum_data payload (= accumulator)
//   busy                 : high whenever not IDLE
module fp_accum_sequencer
   import fp_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = FP_DATA_WIDTH,
   parameter int unsigned M          = FP_M,
   parameter int unsigned E          = FP_E,
   parameter int unsigned LEN_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [LEN_WIDTH-1:0]  len,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  sum_valid,
   output logic [DATA_WIDTH-1:0] sum_data,
   input  logic                  sum_ready,
   output logic                  busy
);

   state_e                state_q,     state_d;
   logic [DATA_WIDTH-1:0] acc_q,       acc_d;
   logic [DATA_WIDTH-1:0] op_q,        op_d;
   logic [LEN_WIDTH-1:0]  rem_q,       rem_d;
   logic                  in_ready_q,  in_ready_d;
   logic                  sum_valid_q, sum_valid_d;
   logic                  busy_q,      busy_d;
   logic [DATA_WIDTH-1:0] add_sum;

   floating_point_adder #(
      .DATA_WIDTH (DATA_WIDTH),
      .M          (M),
      .E          (E)
   ) u_adder (
      .in1 (acc_q),
      .in2 (op_q),
      .out (add_sum)
   );

   // Next-state and register updates; outputs are decoded from the next
   // state so they are flops that reflect the current state.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      op_d    = op_q;
      rem_d   = rem_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               acc_d   = DATA_WIDTH'(FP_ZERO);
               rem_d   = len;
               state_d = (len == '0) ? DONE : ACCEPT;
            end
         end
         ACCEPT: begin
            if (in_valid) begin
               op_d    = in_data;
               rem_d   = rem_q - LEN_WIDTH'(1);
               state_d = ADD;
            end
         end
         ADD: begin
            acc_d   = add_sum;
            state_d = (rem_q == '0) ? DONE : ACCEPT;
         end
         DONE: begin
            // A start arriving with sum_ready is deliberately dropped.
            if (sum_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      in_ready_d  = (state_d == ACCEPT);
      sum_valid_d = (state_d == DONE);
      busy_d      = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         op_q        <= '0;
         rem_q       <= '0;
         in_ready_q  <= 1'b0;
         sum_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         op_q        <= op_d;
         rem_q       <= rem_d;
         in_ready_q  <= in_ready_d;
         sum_valid_q <= sum_valid_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign sum_valid = sum_valid_q;
   assign busy      = busy_q;
   assign sum_data  = acc_q;

endmodule

// File: tb/tb_fp_accum_sequencer.sv
// Bench for fp_accum_sequencer: protocol/sum model checked every cycle plus
// directed runs with hand-computed cycle numbers and sums.
module tb_fp_accum_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  len = '0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready;
   logic        sum_valid;
   logic [31:0] sum_data;
   logic        sum_ready = 1'b0;
   logic        busy;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int t0     = 0;
   bit track  = 1'b0;
   int rq[$];
   int fv     = -1;
   logic [31:0] vec [4];

   fp_accum_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .sum_valid (sum_valid),
      .sum_data  (sum_data),
      .sum_ready (sum_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic real sp_to_real(input logic [31:0] b);
      real m;
      int  e;
      if (b[30:23] == 8'd0) return 0.0;
      m = 1.0 + real'(b[22:0]) / 8388608.0;
      e = int'(b[30:23]) - 127;
      while (e > 0) begin m = m * 2.0; e--; end
      while (e < 0) begin m = m / 2.0; e++; end
      return b[31] ? -m : m;
   endfunction

   function automatic logic [31:0] real_to_sp(input real v);
      real a;
      int  e;
      int  f;
      bit  s;
      if (v == 0.0) return 32'h0;
      s = (v < 0.0);
      a = s ? -v : v;
      e = 0;
      while (a >= 2.0) begin a = a / 2.0; e++; end
      while (a < 1.0)  begin a = a * 2.0; e--; end
      f = $rtoi((a - 1.0) * 8388608.0);
      return {s, 8'(e + 127), 23'(f)};
   endfunction

   // Transaction-level model: a run either waits for an element, is
   // absorbing the last accepted element, or is offering its result.
   bit  m_busy = 1'b0, m_done = 1'b0, m_absorb = 1'b0;
   int  m_n = 0, m_taken = 0;
   real m_sum = 0.0, m_pend = 0.0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 1'b0; m_done = 1'b0; m_absorb = 1'b0;
         m_n = 0; m_taken = 0; m_sum = 0.0;
      end else if (!m_busy) begin
         if (start) begin
            m_busy = 1'b1; m_sum = 0.0; m_n = int'(len); m_taken = 0;
            m_absorb = 1'b0; m_done = (len == 8'd0);
         end
      end else if (m_done) begin
         if (sum_ready) begin m_busy = 1'b0; m_done = 1'b0; end
      end else if (m_absorb) begin
         m_absorb = 1'b0;
         m_sum = m_sum + m_pend;
         if (m_taken == m_n) m_done = 1'b1;
      end else if (in_valid) begin
         m_pend = sp_to_real(in_data);
         m_taken++;
         m_absorb = 1'b1;
      end
   end

   always @(negedge clk) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("in_ready", 32'(in_ready), 32'(m_busy && !m_done && !m_absorb));
      chk("sum_valid", 32'(sum_valid), 32'(m_busy && m_done));
      if (m_busy && m_done) chk("sum_data", sum_data, real_to_sp(m_sum));
      if (track) begin
         if (in_ready) rq.push_back(cyc - t0);
         if (sum_valid && fv < 0) fv = cyc - t0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rq(input string nm, input int cnt, input int e0, input int e1,
                         input int e2, input int e3);
      int ex[4];
      ex = '{e0, e1, e2, e3};
      chk({nm, "_ready_cnt"}, 32'(rq.size()), 32'(cnt));
      for (int i = 0; i < cnt; i++)
         chk({nm, "_ready_cyc"}, 32'((rq.size() > i) ? rq[i] : -1), 32'(ex[i]));
   endtask

   // One full reduction of vec[0..n-1]; gap idles in_valid after each accept,
   // hold keeps sum_ready low for that many DONE cycles.
   task automatic run_txn(input string nm, input int n, input int gap, input int hold,
                          input bit extra_start, input bit hs_start,
                          input logic [31:0] exp_sum, input int exp_fv);
      int k, guard, idle_left;
      bit accepted, did_extra;
      rq.delete();
      fv = -1;
      k = 0; guard = 0; idle_left = 0; did_extra = 1'b0;
      sum_ready = (hold == 0);
      start = 1'b1; len = 8'(n); t0 = cyc; track = 1'b1;
      step();
      start = 1'b0;
      while (k < n && guard < 200) begin
         in_valid = (idle_left == 0);
         in_data  = vec[k];
         if (extra_start && k == 1 && in_ready && !did_extra) begin
            start = 1'b1; len = 8'd7; did_extra = 1'b1;
         end
         accepted = in_ready && in_valid;
         step();
         guard++;
         start = 1'b0;
         if (accepted) begin k++; idle_left = gap; end
         else if (idle_left > 0) idle_left--;
      end
      chk({nm, "_feed_in_time"}, 32'(guard < 200), 32'd1);
      guard = 0;
      while (!sum_valid && guard < 200) begin step(); guard++; end
      chk({nm, "_sum_valid_seen"}, 32'(sum_valid), 32'd1);
      chk({nm, "_sum"}, sum_data, exp_sum);
      for (int h = 0; h < hold; h++) begin
         chk({nm, "_hold_sum"}, sum_data, exp_sum);
         chk({nm, "_hold_busy"}, 32'(busy), 32'd1);
         chk({nm, "_hold_valid"}, 32'(sum_valid), 32'd1);
         step();
      end
      sum_ready = 1'b1;
      if (hs_start) begin start = 1'b1; len = 8'd1; end
      step();
      sum_ready = 1'b0; start = 1'b0; in_valid = 1'b0;
      chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
      chk({nm, "_idle_valid"}, 32'(sum_valid), 32'd0);
      step();
      chk({nm, "_still_idle"}, 32'(busy), 32'd0);
      track = 1'b0;
      chk({nm, "_first_valid_cyc"}, 32'(fv), 32'(exp_fv));
   endtask

   initial begin
      int  k, guard;
      bit  acc;

      #3;
      chk("reset_in_ready", 32'(in_ready), 32'd0);
      chk("reset_sum_valid", 32'(sum_valid), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_sum_data", sum_data, 32'h0);
      step();
      rst_n = 1'b1;
      step();
      step();

      // 1.0 + 2.0 + 3.0 = 6.0
      vec = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h0};
      run_txn("t1", 3, 0, 0, 1'b0, 1'b0, 32'h40C00000, 7);
      chk_rq("t1", 3, 1, 3, 5, 0);

      // empty reduction
      run_txn("t2", 0, 0, 0, 1'b0, 1'b0, 32'h00000000, 1);
      chk_rq("t2", 0, 0, 0, 0, 0);

      // 2.5 + (-2.5) = +0
      vec = '{32'h40200000, 32'hC0200000, 32'h0, 32'h0};
      run_txn("t3", 2, 0, 0, 1'b0, 1'b0, 32'h00000000, 5);

      // 1.0 + 1.0 with input gaps, held result, start dropped at handshake
      vec = '{32'h3F800000, 32'h3F800000, 32'h0, 32'h0};
      run_txn("t4", 2, 3, 5, 1'b0, 1'b1, 32'h40000000, 7);
      chk_rq("t4", 4, 1, 3, 4, 5);

      // 0.5 + 0.25 = 0.75 with a stray start during ACCEPT
      vec = '{32'h3F000000, 32'h3E800000, 32'h0, 32'h0};
      run_txn("t5", 2, 0, 0, 1'b1, 1'b0, 32'h3F400000, 5);
      chk_rq("t5", 2, 1, 3, 0, 0);

      // reset in ADD of a len=4 run
      vec = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
      start = 1'b1; len = 8'd4;
      step();
      start = 1'b0; in_valid = 1'b1; in_data = vec[0];
      k = 0; guard = 0;
      while (k < 2 && guard < 100) begin
         acc = in_ready;
         step();
         guard++;
         if (acc) k++;
      end
      chk("t6_busy_before_reset", 32'(busy), 32'd1);
      chk("t6_in_add", 32'(in_ready), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_busy", 32'(busy), 32'd0);
      chk("t6_async_in_ready", 32'(in_ready), 32'd0);
      chk("t6_async_sum_valid", 32'(sum_valid), 32'd0);
      chk("t6_async_sum_data", sum_data, 32'h0);
      in_valid = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
      vec = '{32'h3F800000, 32'h0, 32'h0, 32'h0};
      run_txn("t6", 1, 0, 0, 1'b0, 1'b0, 32'h3F800000, 3);
      chk_rq("t6", 1, 1, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
